// File: rtl/burst_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : burst_rr_scheduler
// Function : Round-robin owner of a shared burst port. Each grant lasts the
//            winner's latched burst length and the just-served client drops
//            to lowest priority. Optional macro SCHED_WATCHDOG_EN adds an
//            idle-beat forced release with a timeout_oh pulse.
// Revision : 1.0 - initial release
// ============================================================================
module burst_rr_scheduler #(
  parameter int C_NUM_REQUESTORS  = 8,
  parameter int C_LEN_WIDTH       = 8,
  parameter int C_WATCHDOG_CYCLES = 256
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [C_NUM_REQUESTORS-1:0]               req,
  input  logic [C_NUM_REQUESTORS*C_LEN_WIDTH-1:0]   req_len,
  input  logic                                      beat,
  output logic                                      grant_valid,
  output logic [$clog2(C_NUM_REQUESTORS)-1:0]       grant,
  output logic [C_NUM_REQUESTORS-1:0]               grant_oh,
  output logic [C_NUM_REQUESTORS-1:0]               done_oh
`ifdef SCHED_WATCHDOG_EN
  ,
  output logic [C_NUM_REQUESTORS-1:0]               timeout_oh
`endif
);

  localparam int                     c_GNT_W    = $clog2(C_NUM_REQUESTORS);
  localparam logic [c_GNT_W-1:0]     c_LAST_IDX = c_GNT_W'(C_NUM_REQUESTORS - 1);
  localparam logic [C_LEN_WIDTH-1:0] c_LEN_ONE  = C_LEN_WIDTH'(1);

`ifdef SCHED_WATCHDOG_EN
  localparam int               c_WD_W    = ($clog2(C_WATCHDOG_CYCLES) > 0) ? $clog2(C_WATCHDOG_CYCLES) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(C_WATCHDOG_CYCLES - 1);
  localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                        state_q;
  logic [c_GNT_W-1:0]            ptr_q;
  logic [c_GNT_W-1:0]            grant_q;
  logic                          gv_q;
  logic [C_NUM_REQUESTORS-1:0]   grant_oh_q;
  logic [C_NUM_REQUESTORS-1:0]   done_oh_q;
  logic [C_LEN_WIDTH-1:0]        len_q;
  logic [C_LEN_WIDTH-1:0]        cnt_q;
`ifdef SCHED_WATCHDOG_EN
  logic [c_WD_W-1:0]             wd_q;
  logic [C_NUM_REQUESTORS-1:0]   timeout_oh_q;
`endif

  logic                          win_found_d;
  logic [c_GNT_W-1:0]            win_idx_d;
  logic [C_NUM_REQUESTORS-1:0]   win_oh_d;
  logic [C_LEN_WIDTH-1:0]        win_raw_len_d;
  logic [C_LEN_WIDTH-1:0]        win_len_d;

  // Search starts just above the last-served client, so it is examined last.
  always_comb begin
    int idx;
    idx         = 0;
    win_found_d = 1'b0;
    win_idx_d   = '0;
    for (int k = 1; k <= C_NUM_REQUESTORS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= C_NUM_REQUESTORS) begin
        idx = idx - C_NUM_REQUESTORS;
      end
      if (!win_found_d && req[idx]) begin
        win_found_d = 1'b1;
        win_idx_d   = c_GNT_W'(idx);
      end
    end
  end

  always_comb begin
    win_oh_d            = '0;
    win_oh_d[win_idx_d] = 1'b1;
    win_raw_len_d       = req_len[int'(win_idx_d)*C_LEN_WIDTH +: C_LEN_WIDTH];
    win_len_d           = (win_raw_len_d == '0) ? c_LEN_ONE : win_raw_len_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= c_LAST_IDX;
      grant_q      <= '0;
      gv_q         <= 1'b0;
      grant_oh_q   <= '0;
      done_oh_q    <= '0;
      len_q        <= c_LEN_ONE;
      cnt_q        <= '0;
`ifdef SCHED_WATCHDOG_EN
      wd_q         <= '0;
      timeout_oh_q <= '0;
`endif
    end else begin
      done_oh_q    <= '0;
`ifdef SCHED_WATCHDOG_EN
      timeout_oh_q <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            state_q    <= S_BUSY;
            gv_q       <= 1'b1;
            grant_q    <= win_idx_d;
            grant_oh_q <= win_oh_d;
            ptr_q      <= win_idx_d;
            len_q      <= win_len_d;
            cnt_q      <= '0;
`ifdef SCHED_WATCHDOG_EN
            wd_q       <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (beat) begin
`ifdef SCHED_WATCHDOG_EN
            wd_q <= '0;
`endif
            if (cnt_q == (len_q - c_LEN_ONE)) begin
              state_q    <= S_IDLE;
              gv_q       <= 1'b0;
              grant_oh_q <= '0;
              done_oh_q  <= grant_oh_q;
            end else begin
              cnt_q <= cnt_q + c_LEN_ONE;
            end
          end
`ifdef SCHED_WATCHDOG_EN
          else if (wd_q == c_WD_LAST) begin
            state_q      <= S_IDLE;
            gv_q         <= 1'b0;
            grant_oh_q   <= '0;
            timeout_oh_q <= grant_oh_q;
          end else begin
            wd_q <= wd_q + c_WD_ONE;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant_valid = gv_q;
  assign grant       = grant_q;
  assign grant_oh    = grant_oh_q;
  assign done_oh     = done_oh_q;
`ifdef SCHED_WATCHDOG_EN
  assign timeout_oh  = timeout_oh_q;
`endif

endmodule
`default_nettype wire
